// File: rtl/tlb_mmu_if.sv
// Bundle of lookup, TLB-op, and Random/Wired signals between the pipeline/CP0 (master)
// and the joint TLB (slave).
interface tlb_mmu_if #(
   parameter int TLB_ENTRIES  = 16,
   parameter int LOOKUP_PORTS = 2,
   parameter int IDX_W        = $clog2(TLB_ENTRIES)
);
   logic                      k0_uncached;
   logic [7:0]                asid;

   logic [LOOKUP_PORTS-1:0]    lk_valid;
   logic [32*LOOKUP_PORTS-1:0] lk_vaddr;
   logic [LOOKUP_PORTS-1:0]    lk_store;
   logic [LOOKUP_PORTS-1:0]    lk_resp_valid;
   logic [32*LOOKUP_PORTS-1:0] lk_paddr;
   logic [LOOKUP_PORTS-1:0]    lk_uncached;
   logic [LOOKUP_PORTS-1:0]    lk_refill;
   logic [LOOKUP_PORTS-1:0]    lk_invalid;
   logic [LOOKUP_PORTS-1:0]    lk_modified;

   logic                      op_valid;
   logic [1:0]                op_code;
   logic [IDX_W-1:0]          op_index;
   logic [31:0]               op_entryhi;
   logic [31:0]               op_entrylo0;
   logic [31:0]               op_entrylo1;
   logic                      op_ready;
   logic                      op_done;
   logic [31:0]               rd_entryhi;
   logic [31:0]               rd_entrylo0;
   logic [31:0]               rd_entrylo1;
   logic [31:0]               p_index;

   logic [IDX_W-1:0]          wired;
   logic                      wired_we;
   logic [IDX_W-1:0]          random;

   modport master (
      output k0_uncached, asid, lk_valid, lk_vaddr, lk_store,
             op_valid, op_code, op_index, op_entryhi, op_entrylo0, op_entrylo1,
             wired, wired_we,
      input  lk_resp_valid, lk_paddr, lk_uncached, lk_refill, lk_invalid, lk_modified,
             op_ready, op_done, rd_entryhi, rd_entrylo0, rd_entrylo1, p_index, random
   );

   modport slave (
      input  k0_uncached, asid, lk_valid, lk_vaddr, lk_store,
             op_valid, op_code, op_index, op_entryhi, op_entrylo0, op_entrylo1,
             wired, wired_we,
      output lk_resp_valid, lk_paddr, lk_uncached, lk_refill, lk_invalid, lk_modified,
             op_ready, op_done, rd_entryhi, rd_entrylo0, rd_entrylo1, p_index, random
   );
endinterface

// File: rtl/tlb_mmu.sv
// MIPS32 fully-associative joint TLB: registered multi-port translation, CP0 Random/Wired
// replacement, and a three-state engine executing TLBR/TLBWI/TLBWR/TLBP.
module tlb_mmu #(
   parameter int TLB_ENTRIES  = 16,
   parameter int LOOKUP_PORTS = 2,
   parameter int IDX_W        = $clog2(TLB_ENTRIES)
) (
   input logic      clk,
   input logic      reset,
   tlb_mmu_if.slave bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [1:0] OP_TLBR  = 2'd0;
   localparam logic [1:0] OP_TLBWI = 2'd1;
   localparam logic [1:0] OP_TLBWR = 2'd2;
   localparam logic [1:0] OP_TLBP  = 2'd3;

   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(TLB_ENTRIES - 1);

   typedef struct packed {
      logic [18:0] vpn2;
      logic [7:0]  asid;
      logic        g;
      logic [19:0] pfn0;
      logic [2:0]  c0;
      logic        d0;
      logic        v0;
      logic [19:0] pfn1;
      logic [2:0]  c1;
      logic        d1;
      logic        v1;
   } tlb_entry_t;

   typedef struct packed {
      logic [31:0] paddr;
      logic        uncached;
      logic        refill;
      logic        invalid;
      logic        modified;
   } lk_result_t;

   tlb_entry_t tlb_q [TLB_ENTRIES];
   tlb_entry_t tlb_d [TLB_ENTRIES];

   logic [LOOKUP_PORTS-1:0]    lk_resp_valid_q, lk_resp_valid_d;
   logic [32*LOOKUP_PORTS-1:0] lk_paddr_q, lk_paddr_d;
   logic [LOOKUP_PORTS-1:0]    lk_uncached_q, lk_uncached_d;
   logic [LOOKUP_PORTS-1:0]    lk_refill_q, lk_refill_d;
   logic [LOOKUP_PORTS-1:0]    lk_invalid_q, lk_invalid_d;
   logic [LOOKUP_PORTS-1:0]    lk_modified_q, lk_modified_d;
   lk_result_t                 lk_res [LOOKUP_PORTS];

   logic [1:0]       state_q, state_d;
   logic [1:0]       op_code_q, op_code_d;
   logic [IDX_W-1:0] op_index_q, op_index_d;
   logic [IDX_W-1:0] op_rand_q, op_rand_d;
   logic [18:0]      op_vpn2_q, op_vpn2_d;
   logic [7:0]       op_asid_q, op_asid_d;
   logic [25:0]      op_lo0_q, op_lo0_d;
   logic [25:0]      op_lo1_q, op_lo1_d;
   logic [31:0]      rd_entryhi_q, rd_entryhi_d;
   logic [31:0]      rd_entrylo0_q, rd_entrylo0_d;
   logic [31:0]      rd_entrylo1_q, rd_entrylo1_d;
   logic [31:0]      p_index_q, p_index_d;
   logic [IDX_W-1:0] random_q, random_d;

   tlb_entry_t       wr_entry;
   tlb_entry_t       rd_e;
   logic [IDX_W:0]   probe_hit;

   // Returns {hit, index}; scanning downwards leaves the lowest matching index.
   function automatic logic [IDX_W:0] probe(input logic [18:0] vpn2, input logic [7:0] cur_asid);
      logic [IDX_W:0] r;
      r = '0;
      for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
         if (tlb_q[i].vpn2 == vpn2 && (tlb_q[i].g || tlb_q[i].asid == cur_asid)) begin
            r = {1'b1, IDX_W'(i)};
         end
      end
      return r;
   endfunction

   function automatic lk_result_t translate(input logic [31:0] va, input logic store,
                                            input logic [7:0] cur_asid, input logic k0_unc);
      lk_result_t     r;
      logic [IDX_W:0] hit;
      tlb_entry_t     e;
      logic [19:0]    pfn;
      logic [2:0]     c;
      logic           d;
      logic           v;
      r   = '0;
      hit = probe(va[31:13], cur_asid);
      e   = tlb_q[hit[IDX_W-1:0]];
      pfn = va[12] ? e.pfn1 : e.pfn0;
      c   = va[12] ? e.c1   : e.c0;
      d   = va[12] ? e.d1   : e.d0;
      v   = va[12] ? e.v1   : e.v0;
      if (va[31:30] == 2'b10) begin
         r.paddr    = {3'b000, va[28:0]};
         r.uncached = va[29] | k0_unc;
      end else begin
         r.paddr    = {pfn, va[11:0]};
         r.uncached = (c != 3'd3);
         r.refill   = !hit[IDX_W];
         r.invalid  = hit[IDX_W] && !v;
         r.modified = hit[IDX_W] && v && !d && store;
      end
      return r;
   endfunction

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      lk_resp_valid_d = bus.lk_valid;
      lk_paddr_d      = lk_paddr_q;
      lk_uncached_d   = lk_uncached_q;
      lk_refill_d     = lk_refill_q;
      lk_invalid_d    = lk_invalid_q;
      lk_modified_d   = lk_modified_q;
      for (int p = 0; p < LOOKUP_PORTS; p++) begin
         lk_res[p] = translate(bus.lk_vaddr[p*32 +: 32], bus.lk_store[p], bus.asid, bus.k0_uncached);
         if (bus.lk_valid[p]) begin
            lk_paddr_d[p*32 +: 32] = lk_res[p].paddr;
            lk_uncached_d[p]       = lk_res[p].uncached;
            lk_refill_d[p]         = lk_res[p].refill;
            lk_invalid_d[p]        = lk_res[p].invalid;
            lk_modified_d[p]       = lk_res[p].modified;
         end
      end
   end

   assign wr_entry = '{vpn2: op_vpn2_q, asid: op_asid_q, g: op_lo0_q[0] & op_lo1_q[0],
                       pfn0: op_lo0_q[25:6], c0: op_lo0_q[5:3], d0: op_lo0_q[2], v0: op_lo0_q[1],
                       pfn1: op_lo1_q[25:6], c1: op_lo1_q[5:3], d1: op_lo1_q[2], v1: op_lo1_q[1]};
   assign rd_e      = tlb_q[op_index_q];
   assign probe_hit = probe(op_vpn2_q, op_asid_q);

   always_comb begin
      state_d       = state_q;
      op_code_d     = op_code_q;
      op_index_d    = op_index_q;
      op_rand_d     = op_rand_q;
      op_vpn2_d     = op_vpn2_q;
      op_asid_d     = op_asid_q;
      op_lo0_d      = op_lo0_q;
      op_lo1_d      = op_lo1_q;
      rd_entryhi_d  = rd_entryhi_q;
      rd_entrylo0_d = rd_entrylo0_q;
      rd_entrylo1_d = rd_entrylo1_q;
      p_index_d     = p_index_q;
      for (int i = 0; i < TLB_ENTRIES; i++) tlb_d[i] = tlb_q[i];
      case (state_q)
         S_IDLE: begin
            if (bus.op_valid) begin
               op_code_d  = bus.op_code;
               op_index_d = bus.op_index;
               op_rand_d  = random_q;
               op_vpn2_d  = bus.op_entryhi[31:13];
               op_asid_d  = bus.op_entryhi[7:0];
               op_lo0_d   = bus.op_entrylo0[25:0];
               op_lo1_d   = bus.op_entrylo1[25:0];
               state_d    = S_EXEC;
            end
         end
         S_EXEC: begin
            case (op_code_q)
               OP_TLBR: begin
                  rd_entryhi_d  = {rd_e.vpn2, 5'b0, rd_e.asid};
                  rd_entrylo0_d = {6'b0, rd_e.pfn0, rd_e.c0, rd_e.d0, rd_e.v0, rd_e.g};
                  rd_entrylo1_d = {6'b0, rd_e.pfn1, rd_e.c1, rd_e.d1, rd_e.v1, rd_e.g};
               end
               OP_TLBWI: tlb_d[op_index_q] = wr_entry;
               OP_TLBWR: tlb_d[op_rand_q]  = wr_entry;
               OP_TLBP:  p_index_d = probe_hit[IDX_W] ? 32'(probe_hit[IDX_W-1:0]) : 32'h8000_0000;
            endcase
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Random wraps to the top whenever it reaches Wired, so it never enters the wired range.
   always_comb begin
      if (bus.wired_we || random_q <= bus.wired) random_d = IDX_MAX;
      else                                      random_d = random_q - IDX_W'(1);
   end

   // NOTE: the table lives in flops and is cleared on reset so every entry starts invalid.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < TLB_ENTRIES; i++) tlb_q[i] <= '0;
         lk_resp_valid_q <= '0;
         lk_paddr_q      <= '0;
         lk_uncached_q   <= '0;
         lk_refill_q     <= '0;
         lk_invalid_q    <= '0;
         lk_modified_q   <= '0;
         state_q         <= S_IDLE;
         op_code_q       <= '0;
         op_index_q      <= '0;
         op_rand_q       <= '0;
         op_vpn2_q       <= '0;
         op_asid_q       <= '0;
         op_lo0_q        <= '0;
         op_lo1_q        <= '0;
         rd_entryhi_q    <= '0;
         rd_entrylo0_q   <= '0;
         rd_entrylo1_q   <= '0;
         p_index_q       <= 32'h8000_0000;
         random_q        <= IDX_MAX;
      end else begin
         for (int i = 0; i < TLB_ENTRIES; i++) tlb_q[i] <= tlb_d[i];
         lk_resp_valid_q <= lk_resp_valid_d;
         lk_paddr_q      <= lk_paddr_d;
         lk_uncached_q   <= lk_uncached_d;
         lk_refill_q     <= lk_refill_d;
         lk_invalid_q    <= lk_invalid_d;
         lk_modified_q   <= lk_modified_d;
         state_q         <= state_d;
         op_code_q       <= op_code_d;
         op_index_q      <= op_index_d;
         op_rand_q       <= op_rand_d;
         op_vpn2_q       <= op_vpn2_d;
         op_asid_q       <= op_asid_d;
         op_lo0_q        <= op_lo0_d;
         op_lo1_q        <= op_lo1_d;
         rd_entryhi_q    <= rd_entryhi_d;
         rd_entrylo0_q   <= rd_entrylo0_d;
         rd_entrylo1_q   <= rd_entrylo1_d;
         p_index_q       <= p_index_d;
         random_q        <= random_d;
      end
   end

   logic unused_fields;
   assign unused_fields = ^{bus.op_entryhi[12:8], bus.op_entrylo0[31:26], bus.op_entrylo1[31:26]};

   assign bus.lk_resp_valid = lk_resp_valid_q;
   assign bus.lk_paddr      = lk_paddr_q;
   assign bus.lk_uncached   = lk_uncached_q;
   assign bus.lk_refill     = lk_refill_q;
   assign bus.lk_invalid    = lk_invalid_q;
   assign bus.lk_modified   = lk_modified_q;
   assign bus.op_ready      = (state_q == S_IDLE);
   assign bus.op_done       = (state_q == S_DONE);
   assign bus.rd_entryhi    = rd_entryhi_q;
   assign bus.rd_entrylo0   = rd_entrylo0_q;
   assign bus.rd_entrylo1   = rd_entrylo1_q;
   assign bus.p_index       = p_index_q;
   assign bus.random        = random_q;
endmodule
